// File: rtl/btb_update_queue_if.sv
// rtl/btb_update_queue_if.sv - requester, flush, fetch and BTB write-port bundle for btb_update_queue
interface btb_update_queue_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             req0_valid;
    logic [WIDTH-1:0] req0_pc;
    logic [WIDTH-1:0] req0_target;
    logic             req0_ready;
    logic             req1_valid;
    logic [WIDTH-1:0] req1_pc;
    logic [WIDTH-1:0] req1_target;
    logic             req1_ready;
    logic             flush;
    logic [WIDTH-1:0] fetch_pc;
    logic [WIDTH-1:0] btb_w_pc;
    logic [WIDTH-1:0] btb_target;
    logic             btb_load;
    logic [CW-1:0]    count;

    modport master (
        output req0_valid, req0_pc, req0_target, req1_valid, req1_pc, req1_target,
        output flush, fetch_pc,
        input  req0_ready, req1_ready, btb_w_pc, btb_target, btb_load, count
    );

    modport slave (
        input  req0_valid, req0_pc, req0_target, req1_valid, req1_pc, req1_target,
        input  flush, fetch_pc,
        output req0_ready, req1_ready, btb_w_pc, btb_target, btb_load, count
    );
endinterface

// File: rtl/btb_update_queue.sv
// rtl/btb_update_queue.sv - round-robin BTB update FIFO with fetch-conflict deferral; BTBQ_COALESCE_EN enables same-pc target coalescing
module btb_update_queue #(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 4,
    parameter int BIT_ENTRY   = 3,
    parameter int STALL_LIMIT = 2
) (
    input  logic                clk,
    input  logic                rst,
    btb_update_queue_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STALL_LIMIT + 1);

    logic [WIDTH-1:0] pc_mem_q  [DEPTH];
    logic [WIDTH-1:0] tgt_mem_q [DEPTH];
    logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic             rr_q, rr_d;
    logic [SW-1:0]    stall_q, stall_d;

    logic             empty, full, conflict, load;
    logic             grant0, grant1, sel1, win_valid;
    logic [WIDTH-1:0] head_pc, head_tgt, win_pc, win_tgt;
    logic             hit, room, ready0, ready1, accept, alloc, coal;
    logic [AW-1:0]    hit_idx;

    // Arbitration, conflict/deferral decision, handshake and next-state computation
    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == CW'(DEPTH));
        head_pc  = pc_mem_q[head_q];
        head_tgt = tgt_mem_q[head_q];
        conflict = !empty && (head_pc[BIT_ENTRY+1:2] == bus.fetch_pc[BIT_ENTRY+1:2]);
        // A deferred head is forced out once it has waited STALL_LIMIT cycles
        load     = !rst && !bus.flush && !empty && (!conflict || stall_q == SW'(STALL_LIMIT));

        // rr_q = 0 gives req0 priority; an idle requester never blocks the other
        grant0    = !(bus.req1_valid && (rr_q || !bus.req0_valid));
        grant1    = !(bus.req0_valid && (!rr_q || !bus.req1_valid));
        sel1      = bus.req1_valid && grant1;
        win_valid = (bus.req0_valid && grant0) || sel1;
        win_pc    = sel1 ? bus.req1_pc : bus.req0_pc;
        win_tgt   = sel1 ? bus.req1_target : bus.req0_target;

        hit     = 1'b0;
        hit_idx = '0;
`ifdef BTBQ_COALESCE_EN
        // Search occupied slots, skipping a head that leaves this edge; lowest offset wins
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (win_valid && (CW'(i) < count_q) && !(i == 0 && load)
                && pc_mem_q[head_q + AW'(i)] == win_pc) begin
                hit     = 1'b1;
                hit_idx = head_q + AW'(i);
            end
        end
`endif
        room   = !full || hit;
        ready0 = grant0 && room && !bus.flush;
        ready1 = grant1 && room && !bus.flush;
        accept = (bus.req0_valid && ready0) || (bus.req1_valid && ready1);
        alloc  = accept && !hit;
        coal   = accept && hit;

        head_d  = head_q + AW'(load);
        tail_d  = tail_q + AW'(alloc);
        count_d = count_q + CW'(alloc) - CW'(load);
        rr_d    = accept ? !sel1 : rr_q;
        stall_d = stall_q;
        if (load) begin
            stall_d = '0;
        end else if (!empty && stall_q != SW'(STALL_LIMIT)) begin
            stall_d = stall_q + SW'(1);
        end
        if (bus.flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            stall_d = '0;
        end

        bus.req0_ready = ready0;
        bus.req1_ready = ready1;
        bus.btb_load   = load;
        bus.btb_w_pc   = empty ? '0 : head_pc;
        bus.btb_target = empty ? '0 : head_tgt;
        bus.count      = count_q;
    end

    // Pointer, occupancy, priority and stall-counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            rr_q    <= 1'b0;
            stall_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            rr_q    <= rr_d;
            stall_q <= stall_d;
        end
    end

    // Entry storage: allocate at tail, or rewrite the target of a coalesced slot
    always_ff @(posedge clk) begin
        if (alloc) begin
            pc_mem_q[tail_q]  <= win_pc;
            tgt_mem_q[tail_q] <= win_tgt;
        end else if (coal) begin
            tgt_mem_q[hit_idx] <= win_tgt;
        end
    end
endmodule

// File: tb/tb_btb_update_queue.sv
// tb/tb_btb_update_queue.sv - directed bench with queue-based reference model for btb_update_queue
module tb_btb_update_queue;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    btb_update_queue_if #(.WIDTH(32), .DEPTH(4)) bif ();

    btb_update_queue #(.WIDTH(32), .DEPTH(4), .BIT_ENTRY(3), .STALL_LIMIT(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] q_pc[$];
    logic [31:0] q_tg[$];
    int          rr = 0;
    int          stall = 0;
    logic [31:0] log_pc[$];
    logic [31:0] log_tg[$];

    logic e_load, e_r0, e_r1;
    int   e_win, e_hit;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function void eval();
        logic [31:0] h, f, wp;
        int first;
        logic room;
        e_load = 1'b0;
        e_win  = -1;
        e_hit  = -1;
        f = bif.fetch_pc;
        if (q_pc.size() > 0) begin
            h = q_pc[0];
            e_load = !rst && !bif.flush && ((h[4:2] != f[4:2]) || stall == 2);
        end
        if (bif.req0_valid && bif.req1_valid) e_win = rr;
        else if (bif.req0_valid)              e_win = 0;
        else if (bif.req1_valid)              e_win = 1;
`ifdef BTBQ_COALESCE_EN
        if (e_win >= 0) begin
            wp = (e_win == 0) ? bif.req0_pc : bif.req1_pc;
            first = e_load ? 1 : 0;
            for (int j = q_pc.size() - 1; j >= first; j--)
                if (q_pc[j] == wp) e_hit = j;
        end
`else
        wp = 32'h0;
        first = 0;
`endif
        room = (q_pc.size() < 4) || (e_hit >= 0);
        e_r0 = !bif.flush && room && (e_win != 1);
        e_r1 = !bif.flush && room && (e_win != 0);
    endfunction

    // Reference model state update on each active edge
    initial forever begin
        logic acc;
        logic [31:0] wpc, wtg;
        @(posedge clk);
        eval();
        if (rst) begin
            q_pc.delete(); q_tg.delete(); rr = 0; stall = 0;
        end else if (bif.flush) begin
            q_pc.delete(); q_tg.delete(); stall = 0;
        end else begin
            acc = (e_win == 0 && e_r0) || (e_win == 1 && e_r1);
            wpc = (e_win == 1) ? bif.req1_pc : bif.req0_pc;
            wtg = (e_win == 1) ? bif.req1_target : bif.req0_target;
            if (e_load) begin
                void'(q_pc.pop_front()); void'(q_tg.pop_front()); stall = 0;
            end else if (q_pc.size() > 0 && stall < 2) begin
                stall++;
            end
            if (acc) begin
                if (e_hit >= 0) q_tg[e_hit - (e_load ? 1 : 0)] = wtg;
                else begin q_pc.push_back(wpc); q_tg.push_back(wtg); end
                rr = 1 - e_win;
            end
        end
    end

    // Per-cycle comparison against the model, plus a log of DUT writes
    initial forever begin
        @(negedge clk);
        if (bif.btb_load) begin log_pc.push_back(bif.btb_w_pc); log_tg.push_back(bif.btb_target); end
        if (!rst) begin
            eval();
            chk("m_count",  32'(bif.count), q_pc.size());
            chk("m_load",   32'(bif.btb_load), 32'(e_load));
            chk("m_w_pc",   bif.btb_w_pc, (q_pc.size() > 0) ? q_pc[0] : 32'h0);
            chk("m_target", bif.btb_target, (q_tg.size() > 0) ? q_tg[0] : 32'h0);
            chk("m_ready0", 32'(bif.req0_ready), 32'(e_r0));
            chk("m_ready1", 32'(bif.req1_ready), 32'(e_r1));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        bif.req0_valid = 1'b0; bif.req0_pc = '0; bif.req0_target = '0;
        bif.req1_valid = 1'b0; bif.req1_pc = '0; bif.req1_target = '0;
        bif.flush = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        cyc(); cyc();
        rst = 1'b0;
    endtask

    task automatic chk_log(input string nm, input int idx, input logic [31:0] epc, input logic [31:0] etg);
        logic [31:0] apc, atg;
        apc = (idx < log_pc.size()) ? log_pc[idx] : 32'hdead_beef;
        atg = (idx < log_tg.size()) ? log_tg[idx] : 32'hdead_beef;
        chk({nm, "_pc"}, apc, epc);
        chk({nm, "_tgt"}, atg, etg);
    endtask

    initial begin
        int k, guard;
        logic a;
        idle();
        bif.fetch_pc = 32'h0;
        cyc(); cyc();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_count", 32'(bif.count), 0);
        chk("rst_ready0", 32'(bif.req0_ready), 1);
        chk("rst_ready1", 32'(bif.req1_ready), 1);
        chk("rst_load", 32'(bif.btb_load), 0);
        chk("rst_wpc", bif.btb_w_pc, 0);

        // Single update, one-cycle latency to the write port
        cyc();
        bif.fetch_pc = 32'h4;
        bif.req0_valid = 1'b1; bif.req0_pc = 32'h100; bif.req0_target = 32'h200;
        @(negedge clk);
        chk("t1_ready0", 32'(bif.req0_ready), 1);
        cyc();
        bif.req0_valid = 1'b0;
        @(negedge clk);
        chk("t1_load", 32'(bif.btb_load), 1);
        chk("t1_wpc", bif.btb_w_pc, 32'h100);
        chk("t1_tgt", bif.btb_target, 32'h200);
        chk("t1_count", 32'(bif.count), 1);
        cyc();
        @(negedge clk);
        chk("t1_count_after", 32'(bif.count), 0);

        // Round-robin alternation with both requesters valid
        do_reset();
        bif.fetch_pc = 32'h4;
        log_pc.delete(); log_tg.delete();
        for (int i = 0; i < 4; i++) begin
            bif.req0_valid = 1'b1; bif.req0_pc = 32'h1000 + 32'(i) * 16; bif.req0_target = bif.req0_pc + 32'h8000;
            bif.req1_valid = 1'b1; bif.req1_pc = 32'h2000 + 32'(i) * 16; bif.req1_target = bif.req1_pc + 32'h8000;
            cyc();
        end
        idle();
        cyc(); cyc();
        chk("t2_nwrites", log_pc.size(), 4);
        chk_log("t2_w0", 0, 32'h1000, 32'h9000);
        chk_log("t2_w1", 1, 32'h2010, 32'ha010);
        chk_log("t2_w2", 2, 32'h1020, 32'h9020);
        chk_log("t2_w3", 3, 32'h2030, 32'ha030);

        // Fill under a persistent fetch conflict, bounded deferral, then flush
        do_reset();
        bif.fetch_pc = 32'h0;
        for (int i = 0; i < 8; i++) begin
            bif.req0_valid = (i < 7);
            bif.req0_pc = 32'h100 + 32'(i) * 32'h20;
            bif.req0_target = 32'h900 + 32'(i);
            @(negedge clk);
            if (i == 5) begin
                chk("t3_full_count", 32'(bif.count), 4);
                chk("t3_full_ready0", 32'(bif.req0_ready), 0);
                chk("t3_full_load", 32'(bif.btb_load), 0);
            end
            if (i == 6) begin
                chk("t3_forced_load", 32'(bif.btb_load), 1);
                chk("t3_forced_wpc", bif.btb_w_pc, 32'h120);
                chk("t3_nopass_ready0", 32'(bif.req0_ready), 0);
            end
            if (i == 7) begin
                chk("t3_after_count", 32'(bif.count), 3);
                chk("t3_after_ready0", 32'(bif.req0_ready), 1);
            end
            cyc();
        end
        bif.flush = 1'b1;
        bif.req0_valid = 1'b1; bif.req0_pc = 32'h500; bif.req0_target = 32'h600;
        @(negedge clk);
        chk("t4_flush_ready0", 32'(bif.req0_ready), 0);
        chk("t4_flush_load", 32'(bif.btb_load), 0);
        chk("t4_flush_count", 32'(bif.count), 3);
        cyc();
        idle();
        @(negedge clk);
        chk("t4_post_count", 32'(bif.count), 0);

        // Same pc queued twice behind a deferred head
        do_reset();
        bif.fetch_pc = 32'h0;
        log_pc.delete(); log_tg.delete();
        bif.req0_valid = 1'b1; bif.req0_pc = 32'h20; bif.req0_target = 32'h1;
        cyc();
        bif.req0_pc = 32'h40; bif.req0_target = 32'h80;
        cyc();
        bif.req0_pc = 32'h40; bif.req0_target = 32'hc0;
        @(negedge clk);
        chk("t5_ready0", 32'(bif.req0_ready), 1);
        cyc();
        idle();
        @(negedge clk);
`ifdef BTBQ_COALESCE_EN
        chk("t5_count", 32'(bif.count), 2);
`else
        chk("t5_count", 32'(bif.count), 3);
`endif
        cyc();
        bif.fetch_pc = 32'h4;
        cyc(); cyc(); cyc();
`ifdef BTBQ_COALESCE_EN
        chk("t5_nwrites", log_pc.size(), 2);
        chk_log("t5_w0", 0, 32'h20, 32'h1);
        chk_log("t5_w1", 1, 32'h40, 32'hc0);
`else
        chk("t5_nwrites", log_pc.size(), 3);
        chk_log("t5_w0", 0, 32'h20, 32'h1);
        chk_log("t5_w1", 1, 32'h40, 32'h80);
        chk_log("t5_w2", 2, 32'h40, 32'hc0);
`endif

        // Nine entries through the ring with mixed deferrals
        do_reset();
        bif.fetch_pc = 32'h0;
        log_pc.delete(); log_tg.delete();
        k = 0;
        guard = 0;
        while (k < 9 && guard < 200) begin
            bif.req0_valid = 1'b1;
            bif.req0_pc = 32'h300 + 32'(k) * 4;
            bif.req0_target = 32'ha00 + 32'(k);
            @(negedge clk);
            a = bif.req0_ready;
            cyc();
            if (a) k++;
            guard++;
        end
        chk("t6_accept_budget", 32'(guard < 200), 1);
        idle();
        for (int i = 0; i < 20; i++) cyc();
        chk("t6_nwrites", log_pc.size(), 9);
        for (int i = 0; i < 9; i++)
            chk_log("t6_order", i, 32'h300 + 32'(i) * 4, 32'ha00 + 32'(i));

        // Reset asserted while a loadable head is queued
        bif.fetch_pc = 32'h4;
        bif.req0_valid = 1'b1; bif.req0_pc = 32'h600; bif.req0_target = 32'h700;
        cyc();
        bif.req0_pc = 32'h620; bif.req0_target = 32'h720;
        cyc();
        idle();
        rst = 1'b1;
        @(negedge clk);
        chk("t7_rst_load", 32'(bif.btb_load), 0);
        cyc(); cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("t7_rst_count", 32'(bif.count), 0);
        chk("t7_rst_wpc", bif.btb_w_pc, 0);

        cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
